arith_pipe: RTL and testbench
=============================

Name: arith_pipe

Overview:
- Parametrised successor to the fixed 8-bit registered add/subtract-then-mux datapath.
- Computes one of four operations on WIDTH-bit unsigned operands: add, subtract, accumulate, or load.
- Supports optional saturation and carry/borrow flags.
- Result passes through a STAGES-deep valid/ready pipeline with full throughput and backpressure.
- Sits between operand sources and a downstream consumer that may stall.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
STAGES, 2, pipeline depth = latency in cycles when unstalled (>=1)
OCC_W, $clog2(STAGES+1), width of occupancy monitor (derived, do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
a  input  WIDTH  operand A (all ops)
b  input  WIDTH  operand B (ADD)
c  input  WIDTH  operand C, subtrahend (SUB)
op  input  2  00=ADD a+b, 01=SUB a-c, 10=ACC acc+a, 11=LOAD a
sat  input  1  1=saturate result, 0=wrap
in_valid  input  1  operand set valid
in_ready  output  1  block accepts operand set this cycle
out  output  WIDTH  result at pipeline head
out_flag  output  1  carry (ADD/ACC) or borrow (SUB); 0 for LOAD
out_valid  output  1  out/out_flag valid
out_ready  input  1  consumer takes result this cycle
acc_monitor  output  WIDTH  current accumulator register
occupancy_monitor  output  OCC_W  number of valid pipeline stages

Behaviour:
- Reset (async, immediate, any time including mid-stream):
  - all stage valid bits, data and flags = 0
  - acc = 0
  - out = 0, out_flag = 0, out_valid = 0, occupancy_monitor = 0
  - in_ready = 1 once reset deasserts
- Accept = in_valid && in_ready. Only on accept are operands sampled and stage 1 loaded.
- Arithmetic in stage 1, computed at WIDTH+1 bits:
  - ADD: r = a+b; flag = bit WIDTH.
  - SUB: r = a-c; flag = (c > a).
  - ACC: r = acc+a; flag = bit WIDTH.
  - LOAD: r = a; flag = 0.
  - sat=0: result is the low WIDTH bits (wrap).
  - sat=1: ADD/ACC with flag=1 -> all-ones; SUB with flag=1 -> 0.
  - Flag reports the carry/borrow regardless of sat.
- Accumulator:
  - Updated on the same edge as the stage 1 load: ACC -> acc <= final (possibly saturated) r; LOAD -> acc <= a.
  - ADD/SUB leave acc unchanged.
  - Back-to-back ACC/LOAD chain correctly with no bubbles; each uses acc as updated by the prior accepted op.
  - acc is not affected by downstream stalls.
- Pipeline:
  - Stage i (1..STAGES) holds {valid, data, flag}.
  - adv[STAGES] = out_ready || !v[STAGES].
  - adv[i] = !v[i] || adv[i+1] (combinational ready chain).
  - in_ready = adv[1].
  - Stage i+1 loads stage i when adv[i+1]; stage i clears its valid when it moves forward and receives no new entry.
  - out/out_flag/out_valid = last stage registers (registered outputs).
- Latency: result appears on out exactly STAGES cycles after the accept edge when unstalled; one result per cycle sustained while out_ready=1.
- Stall rules:
  - While out_valid && !out_ready, out/out_flag must hold stable.
  - No entry is dropped, duplicated or reordered.
  - in_ready deasserts only when all STAGES stages are valid and out_ready=0.
  - Simultaneous accept and output transfer with a full pipeline is allowed (in_ready=1 via out_ready).
- in_valid=1 with in_ready=0: no sample, no acc change; the source must hold its inputs.
- occupancy_monitor = popcount of stage valid bits; range 0..STAGES.

Test Plan:
- Reset: accept 2 ACC ops, assert reset for 1 cycle mid-flight -> out_valid=0, acc_monitor=0, occupancy=0 immediately, without a clock edge.
- ADD, WIDTH=8, STAGES=2: a=200,b=100,sat=0 -> 2 cycles later out=44, flag=1; same with sat=1 -> out=255, flag=1; a=3,b=4 -> 7, flag=0.
- SUB: a=5,c=9,sat=0 -> out=252, flag=1; sat=1 -> out=0, flag=1; a=9,c=5 -> 4, flag=0.
- Accumulate: back-to-back LOAD 10, ACC 20, ACC 30, then ACC 250 with sat=1 -> outputs 10,30,60,255; acc_monitor=255; flags 0,0,0,1.
- Backpressure: stream 5 ADDs (results 1..5), hold out_ready=0 for 4 cycles -> in_ready=0 with occupancy=2, out held stable; on release, results 1..5 delivered in order, none lost or duplicated.
- Throughput: in_valid=1 and out_ready=1 for 16 cycles with STAGES=3 -> first result at cycle 3, then one result per cycle, in_ready constantly 1.

Source files
------------

// File: rtl/arith_pipe.sv
// arith_pipe: add/sub/accumulate/load datapath feeding a STAGES-deep valid/ready pipeline
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   a, b, c             operands (a for all ops, b for ADD, c is the SUB subtrahend)
//   op                  00=ADD a+b, 01=SUB a-c, 10=ACC acc+a, 11=LOAD a
//   sat                 1 saturates on carry/borrow, 0 wraps
//   in_valid/in_ready   operand handshake
//   out, out_flag       result and carry/borrow at the pipeline head
//   out_valid/out_ready result handshake
//   acc_monitor         accumulator register
//   occupancy_monitor   number of valid stages
module arith_pipe #(
    parameter int WIDTH = 8,
    parameter int STAGES = 2,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       op,
    input  logic             sat,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc_monitor,
    output logic [OCC_W-1:0] occupancy_monitor
);
    logic [WIDTH-1:0]  r_acc;
    logic [STAGES-1:0] r_v, r_f, w_adv;
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [WIDTH:0]    w_add, w_sub, w_accsum;
    logic [WIDTH-1:0]  w_raw, w_res;
    logic              w_flag, w_accept;
    logic [OCC_W-1:0]  w_occ;

    assign w_add    = {1'b0, a} + {1'b0, b};
    assign w_sub    = {1'b0, a} - {1'b0, c};
    assign w_accsum = {1'b0, r_acc} + {1'b0, a};

    always_comb begin
        w_flag = op == 2'b00 ? w_add[WIDTH] : op == 2'b01 ? (c > a) : op == 2'b10 ? w_accsum[WIDTH] : 1'b0;
        w_raw  = op == 2'b00 ? w_add[WIDTH-1:0] : op == 2'b01 ? w_sub[WIDTH-1:0] : op == 2'b10 ? w_accsum[WIDTH-1:0] : a;
        // borrow saturates to zero, carry to all-ones; LOAD never flags
        w_res  = (sat && w_flag) ? (op == 2'b01 ? '0 : '1) : w_raw;
    end

    // stage i may advance iff the consumer takes the head or any stage at or after i is empty;
    // this is the unrolled form of adv[i] = !v[i] || adv[i+1]
    always_comb begin
        w_adv = '0;
        w_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_adv[i] = out_ready || ((~r_v >> i) != '0);
            w_occ    = w_occ + OCC_W'(r_v[i]);
        end
    end

    assign in_ready          = w_adv[0];
    assign w_accept          = in_valid && w_adv[0];
    assign out               = r_d[STAGES-1];
    assign out_flag          = r_f[STAGES-1];
    assign out_valid         = r_v[STAGES-1];
    assign acc_monitor       = r_acc;
    assign occupancy_monitor = w_occ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_v   <= '0;
            r_f   <= '0;
            for (int i = 0; i < STAGES; i++) r_d[i] <= '0;
        end else begin
            // ACC and LOAD (op[1]=1) both write the final stage-1 result into acc
            if (w_accept && op[1]) r_acc <= w_res;
            if (w_adv[0]) begin
                r_v[0] <= w_accept;
                if (w_accept) begin
                    r_d[0] <= w_res;
                    r_f[0] <= w_flag;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i]) begin
                    r_v[i] <= r_v[i-1];
                    r_d[i] <= r_d[i-1];
                    r_f[i] <= r_f[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_arith_pipe.sv
// tb_arith_pipe: self-checking bench for arith_pipe (STAGES=2 main instance, STAGES=3 throughput instance)
module tb_arith_pipe;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, b, c, out, acc_monitor;
    logic [1:0] op, occupancy_monitor;
    logic       sat, in_valid, in_ready, out_flag, out_valid, out_ready;
    logic [7:0] t_a, t_b, t_c, t_out, t_acc_monitor;
    logic [1:0] t_op, t_occupancy_monitor;
    logic       t_sat, t_in_valid, t_in_ready, t_out_flag, t_out_valid, t_out_ready;

    always #5 clk = ~clk;

    arith_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .op(op), .sat(sat),
        .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_flag(out_flag),
        .out_valid(out_valid), .out_ready(out_ready), .acc_monitor(acc_monitor),
        .occupancy_monitor(occupancy_monitor)
    );

    arith_pipe #(.WIDTH(8), .STAGES(3)) u_dut3 (
        .clk(clk), .reset(reset), .a(t_a), .b(t_b), .c(t_c), .op(t_op), .sat(t_sat),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .out(t_out), .out_flag(t_out_flag),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .acc_monitor(t_acc_monitor),
        .occupancy_monitor(t_occupancy_monitor)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         n_pop = 0;
    int         m_acc = 0;
    logic [8:0] q[$];
    logic [8:0] got_q[$];
    logic       acc_ev = 1'b0;
    logic       stall = 1'b0;
    logic [8:0] held = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // reference arithmetic on plain integers: returns {flag, result}
    function automatic logic [8:0] model(input logic [1:0] o, input int x, input int y, input int z,
                                         input logic s, input int acc);
        int   r;
        logic f;
        case (o)
            2'd0:    r = x + y;
            2'd1:    r = x - z;
            2'd2:    r = acc + x;
            default: r = x;
        endcase
        f = (o == 2'd1) ? (z > x) : (o != 2'd3 && r > 255);
        if (f) r = s ? (o == 2'd1 ? 0 : 255) : (o == 2'd1 ? r + 256 : r - 256);
        return {f, r[7:0]};
    endfunction

    // one clock of the main instance: observe handshakes just before the edge, then advance
    task automatic cyc();
        logic [8:0] e;
        #1;
        acc_ev = in_valid && in_ready;
        if (stall) check("hold", {23'd0, out_flag, out}, {23'd0, held});
        stall = out_valid && !out_ready;
        held  = {out_flag, out};
        if (out_valid && out_ready) begin
            n_pop++;
            got_q.push_back({out_flag, out});
            if (q.size() == 0) check("spurious_out", out_valid, 0);
            else begin
                e = q.pop_front();
                check("scoreboard", {23'd0, out_flag, out}, {23'd0, e});
            end
        end
        if (acc_ev) begin
            e = model(op, int'(a), int'(b), int'(c), sat, m_acc);
            if (op[1]) m_acc = int'(e[7:0]);
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] z, input logic s, input logic [7:0] eo, input logic ef);
        op = o; a = x; b = y; c = z; sat = s; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check({tag, "_early"}, out_valid, 0);
        cyc();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_out"}, out, eo);
        check({tag, "_flag"}, out_flag, ef);
        cyc();
    endtask

    initial begin
        logic [1:0] s_op [4] = '{2'd3, 2'd2, 2'd2, 2'd2};
        logic [7:0] s_a  [4] = '{8'd10, 8'd20, 8'd30, 8'd250};
        logic       s_sat[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] s_exp[4] = '{9'd10, 9'd30, 9'd60, 9'h1FF};
        logic [8:0] q3[$];
        logic [8:0] e;
        int         acc3, n3, sent, p0;
        reset = 1'b1;
        {a, b, c, op, sat, in_valid} = '0;
        out_ready = 1'b1;
        {t_a, t_b, t_c, t_op, t_sat, t_in_valid} = '0;
        t_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_occ", occupancy_monitor, 0);
        check("rst_acc", acc_monitor, 0);

        directed("add_wrap", 2'd0, 8'd200, 8'd100, 8'd0, 1'b0, 8'd44, 1'b1);
        directed("add_sat", 2'd0, 8'd200, 8'd100, 8'd0, 1'b1, 8'd255, 1'b1);
        directed("add_small", 2'd0, 8'd3, 8'd4, 8'd0, 1'b0, 8'd7, 1'b0);
        directed("sub_wrap", 2'd1, 8'd5, 8'd0, 8'd9, 1'b0, 8'd252, 1'b1);
        directed("sub_sat", 2'd1, 8'd5, 8'd0, 8'd9, 1'b1, 8'd0, 1'b1);
        directed("sub_pos", 2'd1, 8'd9, 8'd0, 8'd5, 1'b0, 8'd4, 1'b0);

        got_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = s_op[i]; a = s_a[i]; sat = s_sat[i];
            cyc();
            check("acc_accept", acc_ev, 1);
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        check("acc_monitor", acc_monitor, 255);
        check("acc_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("acc_seq", got_q[i], s_exp[i]);

        sent = 1; p0 = n_pop;
        op = 2'd0; b = 8'd0; sat = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 40 && sent <= 5; t++) begin
            out_ready = (t >= 4);
            a = 8'(sent);
            if (t == 2) begin
                #1;
                check("bp_in_ready", in_ready, 0);
                check("bp_occ", occupancy_monitor, 2);
            end
            cyc();
            if (acc_ev) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("bp_count", n_pop - p0, 5);
        check("bp_drain", q.size(), 0);

        out_ready = 1'b0; op = 2'd2; a = 8'd5; in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_acc", acc_monitor, 0);
        check("rst_mid_occ", occupancy_monitor, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete(); m_acc = 0; stall = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_mid_ready", in_ready, 1);

        for (int t = 0; t < 300; t++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); sat = 1'($urandom);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();
        check("rand_drain", q.size(), 0);

        acc3 = 0; n3 = 0;
        t_out_ready = 1'b1;
        for (int t = 0; t < 22; t++) begin
            t_in_valid = t < 16;
            t_op = 2'($urandom); t_a = 8'($urandom); t_b = 8'($urandom); t_c = 8'($urandom); t_sat = 1'($urandom);
            #1;
            if (t < 16) check("tp_in_ready", t_in_ready, 1);
            check("tp_out_valid", t_out_valid, (t >= 3 && t < 19));
            if (t_out_valid) begin
                n3++;
                if (q3.size() == 0) check("tp_spurious", t_out_valid, 0);
                else begin
                    e = q3.pop_front();
                    check("tp_data", {23'd0, t_out_flag, t_out}, {23'd0, e});
                end
            end
            if (t_in_valid && t_in_ready) begin
                e = model(t_op, int'(t_a), int'(t_b), int'(t_c), t_sat, acc3);
                if (t_op[1]) acc3 = int'(e[7:0]);
                q3.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("tp_count", n3, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
